// File: rtl/sym_fir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// SymFirMacSequencer
// Control sequencer for a folded odd-length symmetric FIR of length
// L = 2*N_COEFFS-1. Each accepted sample is written into a circular sample
// RAM of depth L. The sequencer then steps through the N_COEFFS tap pairs,
// driving the pre-adder read addresses, the coefficient index and the MAC
// strobes. It waits MAC_LAT cycles for the MAC pipeline to drain and then
// holds valid_out until the downstream consumer accepts the result.
//
// Optional feature macro: SYM_FIR_SEQ_FLUSH_EN
//   When defined, the sequencer spends L cycles after reset writing zeros to
//   every RAM location before it accepts the first sample.
// ---------------------------------------------------------------------------
module sym_fir_mac_sequencer #(
    parameter int N_COEFFS = 5,
    parameter int MAC_LAT  = 2,
    localparam int L  = 2 * N_COEFFS - 1,
    localparam int AW = $clog2(L),
    localparam int CW = ($clog2(N_COEFFS) > 1) ? $clog2(N_COEFFS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    output logic          ready_in,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          wr_zero,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic          center,
    output logic [CW-1:0] coeff_idx,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          mac_last,
    output logic          valid_out,
    input  logic          ready_out,
    output logic          busy
);

    // The drain counter only needs to count to MAC_LAT-1; keep it at least
    // one bit wide so the MAC_LAT=0 build still elaborates cleanly.
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [AW-1:0] ADDR_LAST  = AW'(L - 1);
    localparam logic [AW:0]   L_WIDE     = (AW + 1)'(L);
    localparam logic [CW-1:0] K_LAST     = CW'(N_COEFFS - 1);
    localparam logic [DW-1:0] DRAIN_LAST = (MAC_LAT > 0) ? DW'(MAC_LAT - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
`ifdef SYM_FIR_SEQ_FLUSH_EN
        , INIT
`endif
    } state_t;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] p;
    logic [CW-1:0] k;
    logic [CW-1:0] k_next;
    logic [DW-1:0] drain_cnt;
    logic          accept;

`ifdef SYM_FIR_SEQ_FLUSH_EN
    logic [AW-1:0] flush_cnt;
`endif

    // Newer sample of a tap pair: (base - off) mod L, evaluated in AW+1 bits
    // so that adding L back never overflows.
    function automatic logic [AW-1:0] addr_sub(input logic [AW-1:0] base,
                                               input logic [CW-1:0] off);
        logic [AW:0] b;
        logic [AW:0] o;
        logic [AW:0] s;
        b = {1'b0, base};
        o = (AW + 1)'(off);
        if (b >= o) begin
            s = b - o;
        end else begin
            s = b + L_WIDE - o;
        end
        return s[AW-1:0];
    endfunction

    // Older sample of a tap pair: (base + 1 + off) mod L; the sum is always
    // below 2*L, so a single conditional subtraction wraps it.
    function automatic logic [AW-1:0] addr_add(input logic [AW-1:0] base,
                                               input logic [CW-1:0] off);
        logic [AW:0] s;
        s = {1'b0, base} + (AW + 1)'(1) + (AW + 1)'(off);
        if (s >= L_WIDE) begin
            s = s - L_WIDE;
        end
        return s[AW-1:0];
    endfunction

    assign k_next   = k + 1'b1;
    assign ready_in = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = valid_in && (state == IDLE);

    // RAM write port: same-cycle write on accept, or the zero flush sweep.
    always_comb begin
        wr_en   = accept;
        wr_addr = wr_ptr;
        wr_zero = 1'b0;
`ifdef SYM_FIR_SEQ_FLUSH_EN
        if (state == INIT) begin
            wr_en   = 1'b1;
            wr_addr = flush_cnt;
            wr_zero = 1'b1;
        end
`endif
    end

    // Sequencer state machine; every read-side and MAC output is registered
    // and loaded one cycle ahead of the tap step it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef SYM_FIR_SEQ_FLUSH_EN
            state     <= INIT;
            flush_cnt <= '0;
`else
            state     <= IDLE;
`endif
            wr_ptr    <= '0;
            p         <= '0;
            k         <= '0;
            drain_cnt <= '0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            coeff_idx <= '0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            mac_last  <= 1'b0;
            center    <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            case (state)
`ifdef SYM_FIR_SEQ_FLUSH_EN
                INIT: begin
                    if (flush_cnt == ADDR_LAST) begin
                        flush_cnt <= '0;
                        wr_ptr    <= '0;
                        state     <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
`endif
                IDLE: begin
                    if (valid_in) begin
                        p         <= wr_ptr;
                        wr_ptr    <= (wr_ptr == ADDR_LAST) ? '0 : wr_ptr + 1'b1;
                        k         <= '0;
                        rd_addr_a <= wr_ptr;
                        rd_addr_b <= addr_add(wr_ptr, '0);
                        coeff_idx <= '0;
                        mac_clr   <= 1'b1;
                        mac_en    <= 1'b1;
                        mac_last  <= (K_LAST == '0);
                        center    <= (K_LAST == '0);
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (k == K_LAST) begin
                        mac_clr   <= 1'b0;
                        mac_en    <= 1'b0;
                        mac_last  <= 1'b0;
                        center    <= 1'b0;
                        drain_cnt <= '0;
                        if (MAC_LAT == 0) begin
                            valid_out <= 1'b1;
                            state     <= OUT;
                        end else begin
                            state     <= DRAIN;
                        end
                    end else begin
                        k         <= k_next;
                        rd_addr_a <= addr_sub(p, k_next);
                        rd_addr_b <= addr_add(p, k_next);
                        coeff_idx <= k_next;
                        mac_clr   <= 1'b0;
                        mac_en    <= 1'b1;
                        mac_last  <= (k_next == K_LAST);
                        center    <= (k_next == K_LAST);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        valid_out <= 1'b1;
                        state     <= OUT;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (ready_out) begin
                        valid_out <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
